// File: rtl/en_window_sampler_if.sv
// Signal bundle between the enable framing stage and the window sampler.
// The master drives the enable/data pair; the slave returns the decoded frame and status.
interface en_window_sampler_if #(
    parameter int BITS_PER_FRAME = 2
);
    logic                      en_in;
    logic                      din;
    logic [BITS_PER_FRAME-1:0] frame_data;
    logic                      frame_valid;
    logic                      len_err;

    modport master (
        output en_in,
        output din,
        input  frame_data,
        input  frame_valid,
        input  len_err
    );

    modport slave (
        input  en_in,
        input  din,
        output frame_data,
        output frame_valid,
        output len_err
    );
endinterface

// File: rtl/en_window_sampler.sv
// Measures each en_in window, samples din at a fixed offset inside it and
// assembles BITS_PER_FRAME samples into a frame, flagging any timing violation.
module en_window_sampler #(
    parameter int WIN_LEN        = 9,
    parameter int BITS_PER_FRAME = 2,
    parameter int SAMPLE_AT      = 4,
    parameter int FRAME_GAP      = 2
) (
    input logic                clk,
    input logic                rst_n,
    en_window_sampler_if.slave bus
);
    localparam int WCNT_W = $clog2(WIN_LEN + 2);
    localparam int GCNT_W = $clog2(FRAME_GAP + 1);
    localparam int BCNT_W = $clog2(BITS_PER_FRAME + 1);

    localparam logic [WCNT_W-1:0] WIN_LEN_C   = WCNT_W'(WIN_LEN);
    localparam logic [WCNT_W-1:0] SAMPLE_AT_C = WCNT_W'(SAMPLE_AT);
    localparam logic [WCNT_W-1:0] WCNT_ONE    = WCNT_W'(1);
    localparam logic [GCNT_W-1:0] GAP_C       = GCNT_W'(FRAME_GAP);
    localparam logic [GCNT_W-1:0] GCNT_ONE    = GCNT_W'(1);
    localparam logic [BCNT_W-1:0] BLAST_C     = BCNT_W'(BITS_PER_FRAME - 1);
    localparam logic [BCNT_W-1:0] BCNT_ONE    = BCNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WIN    = 2'd1,
        GAP    = 2'd2,
        RESYNC = 2'd3
    } state_t;

    state_t                    state_r;
    logic [WCNT_W-1:0]         wcnt_r;
    logic [GCNT_W-1:0]         gcnt_r;
    logic [BCNT_W-1:0]         bcnt_r;
    logic [BITS_PER_FRAME-1:0] shreg_r;
    logic [BITS_PER_FRAME-1:0] frame_data_r;
    logic                      frame_valid_r;
    logic                      len_err_r;

    function automatic logic [BITS_PER_FRAME-1:0] put_bit(
        input logic [BITS_PER_FRAME-1:0] word,
        input logic [BCNT_W-1:0]         idx,
        input logic                      b
    );
        logic [BITS_PER_FRAME-1:0] res;
        res = word;
        for (int i = 0; i < BITS_PER_FRAME; i++) begin
            if (idx == BCNT_W'(i)) begin
                res[i] = b;
            end else begin
                res[i] = word[i];
            end
        end
        return res;
    endfunction

    // Window/gap sequencer with registered frame and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            wcnt_r        <= '0;
            gcnt_r        <= '0;
            bcnt_r        <= '0;
            shreg_r       <= '0;
            frame_data_r  <= '0;
            frame_valid_r <= 1'b0;
            len_err_r     <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            len_err_r     <= 1'b0;
            case (state_r)
                IDLE, GAP: begin
                    if (bus.en_in) begin
                        state_r <= WIN;
                        wcnt_r  <= WCNT_ONE;
                        gcnt_r  <= '0;
                        if (SAMPLE_AT_C == '0) begin
                            shreg_r <= put_bit(shreg_r, bcnt_r, bus.din);
                        end
                    end else if (state_r == GAP && gcnt_r != GAP_C) begin
                        gcnt_r <= gcnt_r + GCNT_ONE;
                        // A long gap while a frame is half built means bits went missing.
                        if ((gcnt_r + GCNT_ONE) == GAP_C && bcnt_r != '0) begin
                            len_err_r <= 1'b1;
                            bcnt_r    <= '0;
                        end
                    end
                end
                WIN: begin
                    if (bus.en_in) begin
                        if (wcnt_r == WIN_LEN_C) begin
                            len_err_r <= 1'b1;
                            bcnt_r    <= '0;
                            gcnt_r    <= '0;
                            state_r   <= RESYNC;
                        end else begin
                            wcnt_r <= wcnt_r + WCNT_ONE;
                            if (wcnt_r == SAMPLE_AT_C) begin
                                shreg_r <= put_bit(shreg_r, bcnt_r, bus.din);
                            end
                        end
                    end else if (wcnt_r != WIN_LEN_C) begin
                        // The falling cycle already counts as the first low of the resync gap.
                        len_err_r <= 1'b1;
                        bcnt_r    <= '0;
                        gcnt_r    <= GCNT_ONE;
                        state_r   <= RESYNC;
                    end else begin
                        gcnt_r  <= GCNT_ONE;
                        state_r <= GAP;
                        if (bcnt_r == BLAST_C) begin
                            frame_data_r  <= shreg_r;
                            frame_valid_r <= 1'b1;
                            bcnt_r        <= '0;
                        end else begin
                            bcnt_r <= bcnt_r + BCNT_ONE;
                        end
                    end
                end
                RESYNC: begin
                    if (bus.en_in) begin
                        gcnt_r <= '0;
                    end else if ((gcnt_r + GCNT_ONE) >= GAP_C) begin
                        gcnt_r  <= '0;
                        state_r <= IDLE;
                    end else begin
                        gcnt_r <= gcnt_r + GCNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    bcnt_r  <= '0;
                    gcnt_r  <= '0;
                end
            endcase
        end
    end

    assign bus.frame_data  = frame_data_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.len_err     = len_err_r;
endmodule

// File: tb/tb_en_window_sampler.sv
// Bench for en_window_sampler: directed framing scenarios plus randomized window
// and gap lengths, checked every cycle against a run-length model of the framing rules.
module tb_en_window_sampler;
    localparam int WIN_LEN   = 9;
    localparam int BPF       = 2;
    localparam int SAMPLE_AT = 4;
    localparam int FRAME_GAP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    en_window_sampler_if #(.BITS_PER_FRAME(BPF)) bus ();

    en_window_sampler #(
        .WIN_LEN(WIN_LEN),
        .BITS_PER_FRAME(BPF),
        .SAMPLE_AT(SAMPLE_AT),
        .FRAME_GAP(FRAME_GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_fv_cyc = -1;
    int prev_fv_cyc = -1;
    int fv_count = 0;
    int le_count = 0;

    // Model state: lengths of the current high and low runs, bits of the frame in progress.
    int           hi_run;
    int           lo_run;
    bit           resync;
    bit           bits_q[$];
    logic [BPF-1:0] m_fd;
    logic         m_fv;
    logic         m_le;

    function automatic void model_reset();
        hi_run = 0;
        lo_run = 0;
        resync = 1'b0;
        bits_q.delete();
        m_fd = '0;
        m_fv = 1'b0;
        m_le = 1'b0;
    endfunction

    function automatic void model_step(input bit e, input bit d);
        m_fv = 1'b0;
        m_le = 1'b0;
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        if (resync) begin
            if (!e) begin
                lo_run++;
                if (lo_run >= FRAME_GAP) begin
                    resync = 1'b0;
                    hi_run = 0;
                end
            end else begin
                lo_run = 0;
            end
            return;
        end
        if (e) begin
            if (hi_run == WIN_LEN) begin
                m_le = 1'b1;
                bits_q.delete();
                resync = 1'b1;
                lo_run = 0;
                hi_run = 0;
            end else begin
                if (hi_run == SAMPLE_AT) bits_q.push_back(d);
                hi_run++;
            end
        end else if (hi_run > 0) begin
            if (hi_run != WIN_LEN) begin
                m_le = 1'b1;
                bits_q.delete();
                resync = 1'b1;
            end else if (bits_q.size() == BPF) begin
                m_fv = 1'b1;
                m_fd = '0;
                foreach (bits_q[i]) m_fd[i] = bits_q[i];
                bits_q.delete();
            end
            lo_run = 1;
            hi_run = 0;
        end else begin
            lo_run++;
            if (lo_run == FRAME_GAP && bits_q.size() != 0) begin
                m_le = 1'b1;
                bits_q.delete();
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic cycle(input bit e, input bit d);
        bus.en_in = e;
        bus.din   = d;
        model_step(e, d);
        @(posedge clk);
        #1;
        cyc++;
        chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
        chk("len_err", 32'(bus.len_err), 32'(m_le));
        chk("frame_data", 32'(bus.frame_data), 32'(m_fd));
        if (bus.frame_valid === 1'b1) begin
            prev_fv_cyc = last_fv_cyc;
            last_fv_cyc = cyc;
            fv_count++;
        end
        if (bus.len_err === 1'b1) le_count++;
    endtask

    task automatic win(input int len, input bit b);
        for (int k = 0; k < len; k++) begin
            cycle(1'b1, (k == SAMPLE_AT) ? b : 1'($urandom));
        end
    endtask

    task automatic lo(input int len);
        for (int k = 0; k < len; k++) begin
            cycle(1'b0, 1'($urandom));
        end
    endtask

    initial begin
        int wl;
        int gl;
        int fv_before;
        int le_before;
        bus.en_in = 1'b0;
        bus.din   = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_fv", 32'(bus.frame_valid), 32'd0);
        chk("reset_le", 32'(bus.len_err), 32'd0);
        chk("reset_fd", 32'(bus.frame_data), 32'd0);
        rst_n = 1'b1;

        // Single frame 1,0 after a one-cycle low lead-in.
        lo(1);
        win(WIN_LEN, 1'b1);
        lo(1);
        win(WIN_LEN, 1'b0);
        lo(1);
        chk("t1_fv", 32'(bus.frame_valid), 32'd1);
        chk("t1_fd", 32'(bus.frame_data), 32'h1);
        lo(1);
        chk("t1_fv_drop", 32'(bus.frame_valid), 32'd0);
        chk("t1_pulses", 32'(fv_count), 32'd1);
        chk("t1_no_err", 32'(le_count), 32'd0);

        // Back-to-back frames 0,1 then 1,1.
        win(WIN_LEN, 1'b0);
        lo(1);
        win(WIN_LEN, 1'b1);
        lo(1);
        chk("t2_fd_a", 32'(bus.frame_data), 32'h2);
        lo(1);
        win(WIN_LEN, 1'b1);
        lo(1);
        win(WIN_LEN, 1'b1);
        lo(1);
        chk("t2_fd_b", 32'(bus.frame_data), 32'h3);
        chk("t2_spacing", 32'(last_fv_cyc - prev_fv_cyc), 32'(2 * WIN_LEN + 1 + FRAME_GAP));
        lo(1);

        // Short first window, then recovery with frame 0,1.
        fv_before = fv_count;
        win(7, 1'b1);
        lo(1);
        chk("t3_le", 32'(bus.len_err), 32'd1);
        chk("t3_fv", 32'(bus.frame_valid), 32'd0);
        lo(1);
        win(WIN_LEN, 1'b0);
        lo(1);
        win(WIN_LEN, 1'b1);
        lo(1);
        chk("t3_fd", 32'(bus.frame_data), 32'h2);
        chk("t3_pulses", 32'(fv_count - fv_before), 32'd1);
        lo(1);

        // Over-long window: error right after the (WIN_LEN+1)th high sample.
        for (int k = 0; k < WIN_LEN + 2; k++) begin
            cycle(1'b1, 1'($urandom));
            if (k == WIN_LEN) chk("t4_le", 32'(bus.len_err), 32'd1);
        end
        chk("t4_fd_hold", 32'(bus.frame_data), 32'h2);
        lo(2);
        win(WIN_LEN, 1'b1);
        lo(1);
        win(WIN_LEN, 1'b1);
        lo(1);
        chk("t4_fd", 32'(bus.frame_data), 32'h3);
        lo(1);

        // One good window then a 3-cycle gap: exactly one error, then frame 1,0.
        le_before = le_count;
        win(WIN_LEN, 1'b1);
        lo(1);
        chk("t5_le_first", 32'(bus.len_err), 32'd0);
        lo(1);
        chk("t5_le", 32'(bus.len_err), 32'd1);
        lo(1);
        chk("t5_le_once", 32'(le_count - le_before), 32'd1);
        win(WIN_LEN, 1'b1);
        lo(1);
        win(WIN_LEN, 1'b0);
        lo(1);
        chk("t5_fd", 32'(bus.frame_data), 32'h1);
        lo(1);

        // Reset in the middle of window 1.
        win(WIN_LEN, 1'b1);
        lo(1);
        win(5, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_fd", 32'(bus.frame_data), 32'd0);
        chk("t6_rst_fv", 32'(bus.frame_valid), 32'd0);
        chk("t6_rst_le", 32'(bus.len_err), 32'd0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        rst_n = 1'b1;
        lo(1);
        win(WIN_LEN, 1'b0);
        lo(1);
        win(WIN_LEN, 1'b1);
        lo(1);
        chk("t6_fd", 32'(bus.frame_data), 32'h2);
        lo(1);

        // Randomized framing with occasional length and gap disturbances.
        for (int f = 0; f < 200; f++) begin
            for (int w = 0; w < BPF; w++) begin
                wl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(WIN_LEN - 3, WIN_LEN + 3)) : WIN_LEN;
                win(wl, 1'($urandom));
                if (w == BPF - 1) begin
                    gl = int'($urandom_range(FRAME_GAP, FRAME_GAP + 3));
                end else begin
                    gl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 1;
                end
                lo(gl);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
